// File: rtl/bram_nib2byte_fifo_ctrl.sv
// Nibble-in / byte-out FIFO controller for a 4Kx4 (port A) / 2Kx9 (port B) dual-port block RAM.
// Optional BRAM_FIFO_LEVEL_EN adds a registered LEVEL output (nibbles held, including the output byte).
module bram_nib2byte_fifo_ctrl #(
  parameter int AW_NIB = 12
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FLUSH,
  input  logic              WR_VALID,
  input  logic [3:0]        WR_DATA,
  output logic              WR_READY,
  output logic              RD_VALID,
  output logic [7:0]        RD_DATA,
  input  logic              RD_READY,
  output logic              FULL,
  output logic              EMPTY,
  output logic [AW_NIB-1:0] ADDRA,
  output logic [3:0]        DIA,
  output logic              ENA,
  output logic              WEA,
  output logic [AW_NIB-2:0] ADDRB,
  output logic              ENB,
  output logic              WEB,
  output logic [7:0]        DIB,
  output logic              DIPB,
  output logic              SSRA,
  output logic              SSRB,
  input  logic [7:0]        DOB
`ifdef BRAM_FIFO_LEVEL_EN
  ,
  output logic [AW_NIB:0]   LEVEL
`endif
);

  logic [AW_NIB:0]   wptr_q, wptr_d;
  logic [AW_NIB-1:0] rptr_q, rptr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [AW_NIB:0]   occ_nib;
  logic              avail_nz;
  logic              push;
  logic              issue;

  // occ_nib never exceeds 2**AW_NIB, so its top bit alone marks full.
  assign occ_nib  = wptr_q - {rptr_q, 1'b0};
  assign avail_nz = |occ_nib[AW_NIB:1];
  assign FULL     = occ_nib[AW_NIB];
  assign WR_READY = ~FULL;
  assign push     = WR_VALID & WR_READY & ~FLUSH;
  assign issue    = avail_nz & (~rd_valid_q | RD_READY) & ~FLUSH;

  assign RD_VALID = rd_valid_q;
  assign RD_DATA  = DOB;
  assign EMPTY    = ~avail_nz & ~rd_valid_q;

  assign ADDRA = wptr_q[AW_NIB-1:0];
  assign DIA   = WR_DATA;
  assign ENA   = push;
  assign WEA   = push;
  assign ADDRB = rptr_q[AW_NIB-2:0];
  assign ENB   = issue;
  assign WEB   = 1'b0;
  assign DIB   = 8'h00;
  assign DIPB  = 1'b0;
  assign SSRA  = 1'b0;
  assign SSRB  = 1'b0;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rd_valid_d = rd_valid_q;
    if (FLUSH) begin
      wptr_d     = '0;
      rptr_d     = '0;
      rd_valid_d = 1'b0;
    end else begin
      if (push)
        wptr_d = wptr_q + 1'b1;
      // Withholding ENB while the consumer stalls keeps the RAM output register, and so RD_DATA, stable.
      if (issue) begin
        rptr_d     = rptr_q + 1'b1;
        rd_valid_d = 1'b1;
      end else if (RD_READY) begin
        rd_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef BRAM_FIFO_LEVEL_EN
  logic [AW_NIB:0] level_q, level_d;

  always_comb begin
    level_d = occ_nib + (rd_valid_q ? (AW_NIB+1)'(2) : (AW_NIB+1)'(0));
    if (FLUSH)
      level_d = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      level_q <= '0;
    else
      level_q <= level_d;
  end

  assign LEVEL = level_q;
`endif

endmodule

// File: tb/tb_bram_nib2byte_fifo_ctrl.sv
// Directed bench for bram_nib2byte_fifo_ctrl with a behavioural RAMB16_S4_S9 (x4 port A / x8 port B).
module tb_bram_nib2byte_fifo_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N, FLUSH, WR_VALID, RD_READY;
  logic [3:0]  WR_DATA;
  logic        WR_READY, RD_VALID, FULL, EMPTY;
  logic [7:0]  RD_DATA;
  logic [11:0] ADDRA;
  logic [3:0]  DIA;
  logic        ENA, WEA, ENB, WEB, DIPB, SSRA, SSRB;
  logic [10:0] ADDRB;
  logic [7:0]  DIB;
  logic [7:0]  DOB;
`ifdef BRAM_FIFO_LEVEL_EN
  logic [12:0] LEVEL;
`endif

  always #5 CLK = ~CLK;

  bram_nib2byte_fifo_ctrl #(.AW_NIB(12)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
    .WR_VALID(WR_VALID), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
    .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .RD_READY(RD_READY),
    .FULL(FULL), .EMPTY(EMPTY),
    .ADDRA(ADDRA), .DIA(DIA), .ENA(ENA), .WEA(WEA),
    .ADDRB(ADDRB), .ENB(ENB), .WEB(WEB), .DIB(DIB), .DIPB(DIPB),
    .SSRA(SSRA), .SSRB(SSRB), .DOB(DOB)
`ifdef BRAM_FIFO_LEVEL_EN
    , .LEVEL(LEVEL)
`endif
  );

  // RAM model: byte b on port B is nibble 2b (low) and 2b+1 (high) on port A.
  logic [3:0] mem [4096];
  always @(posedge CLK) begin
    if (ENA && WEA) mem[ADDRA] <= DIA;
    if (ENB) DOB <= {mem[{ADDRB, 1'b1}], mem[{ADDRB, 1'b0}]};
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
  logic       sb_on = 1'b0;
  logic [7:0] sb_q [$];
  int unsigned rd_cnt = 0;
  logic [7:0] last_byte;
  logic       half_vld = 1'b0;
  logic [3:0] half_nib;
  always @(negedge CLK) begin
    if (RST_N && RD_VALID && RD_READY) begin
      rd_cnt++;
      last_byte = RD_DATA;
      if (sb_on) begin
        if (sb_q.size() == 0) chk("sb_underflow", {24'h0, RD_DATA}, 32'hFFFF_FFFF);
        else chk("sb_byte", {24'h0, RD_DATA}, {24'h0, sb_q.pop_front()});
      end
    end
    if (sb_on && RST_N && WR_VALID && WR_READY && !FLUSH) begin
      if (half_vld) sb_q.push_back({WR_DATA, half_nib});
      else half_nib = WR_DATA;
      half_vld = ~half_vld;
    end
  end

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    FLUSH = 0; WR_VALID = 0; WR_DATA = 0; RD_READY = 0;
    RST_N = 0;
    cyc();
    RST_N = 1;
    cyc();
  endtask

  task automatic push1(input logic [3:0] n);
    WR_VALID = 1; WR_DATA = n;
    cyc();
    WR_VALID = 0;
  endtask

  int unsigned acc, base, pushed;
  logic [3:0] lo, hi;

  initial begin
    RST_N = 0; FLUSH = 0; WR_VALID = 0; WR_DATA = 0; RD_READY = 0;
    cyc(); cyc();
    chk("rst_rd_valid", RD_VALID, 0);
    chk("rst_full", FULL, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_wr_ready", WR_READY, 1);
    chk("rst_ena", ENA, 0);
    chk("rst_enb", ENB, 0);
    chk("rst_web", WEB, 0);
`ifdef BRAM_FIFO_LEVEL_EN
    chk("rst_level", LEVEL, 0);
`endif
    RST_N = 1;
    cyc();

    // 1: two nibbles -> one byte, 2 cycles from second push to RD_VALID
    RD_READY = 1;
    WR_VALID = 1; WR_DATA = 4'h3; #1;
    chk("t1_ena0", ENA, 1); chk("t1_addra0", ADDRA, 0); chk("t1_enb_a", ENB, 0);
    cyc();
    WR_DATA = 4'hA; #1;
    chk("t1_addra1", ADDRA, 1); chk("t1_enb_b", ENB, 0);
    cyc();
    WR_VALID = 0; #1;
    chk("t1_enb_issue", ENB, 1); chk("t1_addrb", ADDRB, 0);
    cyc();
    chk("t1_rd_valid", RD_VALID, 1); chk("t1_rd_data", RD_DATA, 8'hA3); chk("t1_enb_c", ENB, 0);
    cyc();
    chk("t1_rd_valid_off", RD_VALID, 0); chk("t1_empty", EMPTY, 1);

    // 2: fill; one byte is prefetched into the output register, so 4098 nibbles are accepted
    do_reset();
    WR_VALID = 1; acc = 0;
    for (int c = 0; c < 5000 && WR_READY; c++) begin
      WR_DATA = acc[3:0];
      cyc();
      acc++;
    end
    chk("t2_accepted", acc, 4098);
    chk("t2_full", FULL, 1);
    chk("t2_wr_ready", WR_READY, 0);
    WR_DATA = 4'hF; #1;
    chk("t2_wea_blocked", WEA, 0); chk("t2_ena_blocked", ENA, 0);
    chk("t2_held", RD_DATA, 8'h10);
    cyc();
`ifdef BRAM_FIFO_LEVEL_EN
    chk("t2_level", LEVEL, 4098);
`endif
    WR_VALID = 0; RD_READY = 1; #1;
    chk("t2_pop_enb", ENB, 1);
    cyc();
    RD_READY = 0;
    chk("t2_wr_ready_after_pop", WR_READY, 1);
    chk("t2_full_after_pop", FULL, 0);
    chk("t2_next_byte", RD_DATA, 8'h32);

    // 3: backpressure for 5 cycles, then back-to-back delivery
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_enb_hold", ENB, 0);
      cyc();
      chk("t3_data_hold", RD_DATA, 8'h32);
      chk("t3_valid_hold", RD_VALID, 1);
    end
    RD_READY = 1;
    for (int k = 2; k < 6; k++) begin
      cyc();
      lo = 4'(2 * k); hi = 4'(2 * k + 1);
      chk("t3_b2b_valid", RD_VALID, 1);
      chk("t3_b2b_data", RD_DATA, {hi, lo});
    end
    RD_READY = 0;

    // 4: random stream through both pointer wraps, checked by the scoreboard
    do_reset();
    sb_on = 1; base = rd_cnt; pushed = 0;
    for (int c = 0; c < 40000 && pushed < 10000; c++) begin
      WR_VALID = ($urandom_range(0, 3) != 0);
      WR_DATA  = 4'($urandom);
      RD_READY = ($urandom_range(0, 2) != 0);
      #1;
      if (WR_VALID && WR_READY) pushed++;
      cyc();
    end
    WR_VALID = 0; RD_READY = 1;
    for (int c = 0; c < 3000 && (sb_q.size() != 0 || RD_VALID); c++) cyc();
    chk("t4_pushed", pushed, 10000);
    chk("t4_bytes", rd_cnt - base, 5000);
    chk("t4_sb_left", sb_q.size(), 0);
    sb_on = 0;

    // 5: odd nibble count stays pending until its partner arrives
    do_reset();
    RD_READY = 1; base = rd_cnt;
    push1(4'h5); push1(4'h6); push1(4'h7);
    for (int c = 0; c < 6; c++) cyc();
    chk("t5_one_byte", rd_cnt - base, 1);
    chk("t5_byte0", last_byte, 8'h65);
    chk("t5_empty_pending", EMPTY, 1);
    push1(4'h8);
    for (int c = 0; c < 4; c++) cyc();
    chk("t5_two_bytes", rd_cnt - base, 2);
    chk("t5_byte1", last_byte, 8'h87);

    // 6: FLUSH with a push pending, then async reset mid-stream
    do_reset();
    push1(4'h1); push1(4'h2); push1(4'h3); push1(4'h4);
    FLUSH = 1; WR_VALID = 1; WR_DATA = 4'hC; #1;
    chk("t6_flush_ena", ENA, 0); chk("t6_flush_wea", WEA, 0); chk("t6_flush_enb", ENB, 0);
    cyc();
    FLUSH = 0; WR_VALID = 0;
    chk("t6_flush_empty", EMPTY, 1);
    chk("t6_flush_rd_valid", RD_VALID, 0);
    chk("t6_flush_addra", ADDRA, 0);
`ifdef BRAM_FIFO_LEVEL_EN
    chk("t6_flush_level", LEVEL, 0);
`endif
    push1(4'h9); push1(4'hB); push1(4'hD);
    cyc();
    chk("t6_pre_rst_valid", RD_VALID, 1);
    #3;
    RST_N = 0; #1;
    chk("t6_arst_rd_valid", RD_VALID, 0);
    chk("t6_arst_empty", EMPTY, 1);
    chk("t6_arst_full", FULL, 0);
    chk("t6_arst_wr_ready", WR_READY, 1);
    chk("t6_arst_addra", ADDRA, 0);
    chk("t6_arst_enb", ENB, 0);
    cyc();
    RST_N = 1;
    cyc();
    RD_READY = 1;
    push1(4'h1);
    WR_VALID = 1; WR_DATA = 4'h2; #1;
    chk("t6_addra_after_rst", ADDRA, 1);
    cyc();
    WR_VALID = 0; #1;
    chk("t6_enb", ENB, 1); chk("t6_addrb", ADDRB, 0);
    cyc();
    chk("t6_rd_valid", RD_VALID, 1);
    chk("t6_rd_data", RD_DATA, 8'h21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
